// File: rtl/keccak_lane_absorber.sv
// Keccak-f[1600] absorb front-end: XORs serial message lanes into the rate part of the
// 5x5 lane array, hands the array to the permutation, then reloads the permuted result.
module keccak_lane_absorber #(
   parameter int LANE_W     = 64,
   parameter int RATE_LANES = 17
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          init,
   input  logic                          lane_valid,
   output logic                          lane_ready,
   input  logic [LANE_W-1:0]             lane_data,
   input  logic                          lane_last,
   output logic [4:0][4:0][LANE_W-1:0]   state_out,
   output logic                          state_out_valid,
   input  logic                          state_out_ready,
   input  logic [4:0][4:0][LANE_W-1:0]   state_in,
   input  logic                          state_in_valid,
   output logic [15:0]                   block_count
);

   typedef enum logic [1:0] {
      ABSORB,
      PRESENT,
      WAIT_PERM
   } fsm_e;

   // Coordinates of the final rate lane; reaching it ends the block without lane_last.
   localparam logic [2:0] LAST_X = 3'((RATE_LANES - 1) % 5);
   localparam logic [2:0] LAST_Y = 3'((RATE_LANES - 1) / 5);

   fsm_e                         fsm_q, fsm_d;
   logic [2:0]                   x_q, x_d;
   logic [2:0]                   y_q, y_d;
   logic [15:0]                  block_count_q, block_count_d;
   logic [4:0][4:0][LANE_W-1:0]  state_q, state_d;
   logic                         lane_fire;
   logic                         at_last_lane;

   assign lane_ready      = (fsm_q == ABSORB) && !init && !rst;
   assign lane_fire       = lane_valid && lane_ready;
   assign at_last_lane    = (x_q == LAST_X) && (y_q == LAST_Y);
   assign state_out       = state_q;
   assign state_out_valid = (fsm_q == PRESENT);
   assign block_count     = block_count_q;

   always_comb begin
      // NOTE: every _d gets its hold value first so no path can infer a latch.
      fsm_d         = fsm_q;
      x_d           = x_q;
      y_d           = y_q;
      block_count_d = block_count_q;
      state_d       = state_q;

      if (init) begin
         fsm_d   = ABSORB;
         x_d     = '0;
         y_d     = '0;
         state_d = '0;
      end else begin
         unique case (fsm_q)
            ABSORB: begin
               if (lane_fire) begin
                  state_d[x_q][y_q] = state_q[x_q][y_q] ^ lane_data;
                  if (x_q == 3'd4) begin
                     x_d = '0;
                     y_d = y_q + 3'd1;
                  end else begin
                     x_d = x_q + 3'd1;
                  end
                  if (lane_last || at_last_lane) fsm_d = PRESENT;
               end
            end
            PRESENT: begin
               if (state_out_ready) begin
                  fsm_d         = WAIT_PERM;
                  block_count_d = block_count_q + 16'd1;
               end
            end
            WAIT_PERM: begin
               if (state_in_valid) begin
                  state_d = state_in;
                  x_d     = '0;
                  y_d     = '0;
                  fsm_d   = ABSORB;
               end
            end
            default: fsm_d = ABSORB;
         endcase
      end
   end

   // NOTE: the lane array is a real register file that must come up zeroed, so it is reset too.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q         <= ABSORB;
         x_q           <= '0;
         y_q           <= '0;
         block_count_q <= '0;
         state_q       <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values.
         fsm_q         <= fsm_d;
         x_q           <= x_d;
         y_q           <= y_d;
         block_count_q <= block_count_d;
         state_q       <= state_d;
      end
   end

endmodule

// File: tb/tb_keccak_lane_absorber.sv
// Directed bench for keccak_lane_absorber: SHAKE256 instance for the main flow and a
// SHAKE128 instance for the 21-lane block boundary.
module tb_keccak_lane_absorber;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] PA5  = 64'hA5A5_A5A5_A5A5_A5A5;
   localparam logic [63:0] P5A  = 64'h5A5A_5A5A_5A5A_5A5A;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    init, lane_valid, lane_last, state_out_ready, state_in_valid;
   logic [63:0]             lane_data;
   logic [4:0][4:0][63:0]   state_in;
   logic                    lane_ready, state_out_valid;
   logic [4:0][4:0][63:0]   state_out;
   logic [15:0]             block_count;

   logic                    init21, lane_valid21, lane_last21, state_out_ready21;
   logic [63:0]             lane_data21;
   logic [4:0][4:0][63:0]   state_in21;
   logic                    lane_ready21, state_out_valid21;
   logic [4:0][4:0][63:0]   state_out21;
   logic [15:0]             block_count21;

   logic [4:0][4:0][63:0]   exp_st;
   logic [4:0][4:0][63:0]   snap;
   int                      checks = 0;
   int                      errors = 0;

   always #5 clk = ~clk;

   keccak_lane_absorber #(.LANE_W(64), .RATE_LANES(17)) dut (
      .clk(clk), .rst(rst), .init(init),
      .lane_valid(lane_valid), .lane_ready(lane_ready),
      .lane_data(lane_data), .lane_last(lane_last),
      .state_out(state_out), .state_out_valid(state_out_valid),
      .state_out_ready(state_out_ready),
      .state_in(state_in), .state_in_valid(state_in_valid),
      .block_count(block_count)
   );

   keccak_lane_absorber #(.LANE_W(64), .RATE_LANES(21)) dut21 (
      .clk(clk), .rst(rst), .init(init21),
      .lane_valid(lane_valid21), .lane_ready(lane_ready21),
      .lane_data(lane_data21), .lane_last(lane_last21),
      .state_out(state_out21), .state_out_valid(state_out_valid21),
      .state_out_ready(state_out_ready21),
      .state_in(state_in21), .state_in_valid(1'b0),
      .block_count(block_count21)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            check($sformatf("%s A[%0d][%0d]", tag, x, y), state_out[x][y], exp_st[x][y]);
   endtask

   // Drives one lane on the 17-lane instance; called and returned on a negedge.
   task automatic send(input logic [63:0] d, input logic last);
      lane_valid = 1'b1;
      lane_data  = d;
      lane_last  = last;
      #1 check("lane_ready before accept", lane_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      lane_valid = 1'b0;
      lane_last  = 1'b0;
   endtask

   task automatic handshake();
      state_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      state_out_ready = 1'b0;
   endtask

   task automatic return_state(input logic [63:0] v);
      for (int i = 0; i < 25; i++) state_in[i % 5][i / 5] = v;
      state_in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      state_in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; init = 1'b0; lane_valid = 1'b0; lane_last = 1'b0; lane_data = '0;
      state_out_ready = 1'b0; state_in_valid = 1'b0; state_in = '0;
      init21 = 1'b0; lane_valid21 = 1'b0; lane_last21 = 1'b0; lane_data21 = '0;
      state_out_ready21 = 1'b0; state_in21 = '0;

      // Reset values
      #2;
      check("reset lane_ready", lane_ready, 1'b0);
      check("reset state_out_valid", state_out_valid, 1'b0);
      check("reset block_count", block_count, 16'd0);
      exp_st = '0;
      check_state("reset");
      @(negedge clk);
      rst = 1'b0;
      init = 1'b1;
      #1 check("lane_ready during init", lane_ready, 1'b0);
      @(negedge clk);
      init = 1'b0;

      // Test 1: full 17-lane block
      for (int i = 0; i < 17; i++) begin
         check("no early present", state_out_valid, 1'b0);
         send(64'(i + 1), i == 16);
      end
      check("t1 state_out_valid", state_out_valid, 1'b1);
      check("t1 lane_ready in PRESENT", lane_ready, 1'b0);
      check("t1 block_count before", block_count, 16'd0);
      exp_st = '0;
      for (int i = 0; i < 17; i++) exp_st[i % 5][i / 5] = 64'(i + 1);
      check_state("t1");
      handshake();
      check("t1 block_count after", block_count, 16'd1);
      check("t1 valid in WAIT_PERM", state_out_valid, 1'b0);
      check("t1 lane_ready in WAIT_PERM", lane_ready, 1'b0);
      return_state('0);
      check("lane_ready after reload", lane_ready, 1'b1);

      // Test 2: short block of three all-ones lanes
      send(ONES, 1'b0);
      send(ONES, 1'b0);
      check("t2 not yet present", state_out_valid, 1'b0);
      send(ONES, 1'b1);
      check("t2 state_out_valid", state_out_valid, 1'b1);
      exp_st = '0;
      exp_st[0][0] = ONES; exp_st[1][0] = ONES; exp_st[2][0] = ONES;
      check_state("t2");

      // Test 4: stall in PRESENT with a lane offered and a stray state_in_valid
      lane_valid = 1'b1; lane_data = 64'h1234; lane_last = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (c == 4) begin
            for (int i = 0; i < 25; i++) state_in[i % 5][i / 5] = PA5;
            state_in_valid = 1'b1;
         end else begin
            state_in_valid = 1'b0;
         end
         #1 check("t4 lane_ready held low", lane_ready, 1'b0);
         check("t4 valid held", state_out_valid, 1'b1);
         @(negedge clk);
      end
      lane_valid = 1'b0; lane_last = 1'b0; state_in_valid = 1'b0;
      check_state("t4 stable");
      check("t4 block_count", block_count, 16'd1);
      handshake();
      check("t4 block_count after", block_count, 16'd2);

      // Test 3: reload A5 pattern, absorb one 5A lane
      return_state(PA5);
      send(P5A, 1'b1);
      check("t3 state_out_valid", state_out_valid, 1'b1);
      for (int i = 0; i < 25; i++) exp_st[i % 5][i / 5] = PA5;
      exp_st[0][0] = ONES;
      check_state("t3");
      handshake();
      check("t3 block_count", block_count, 16'd3);
      return_state('0);

      // Test 5: init mid-block at index 7
      for (int i = 0; i < 7; i++) send(64'h11 * 64'(i + 1), 1'b0);
      snap = state_out;
      check("t5 lane 6 landed A[1][1]", snap[1][1], 64'h77);
      lane_valid = 1'b1; lane_data = 64'hBEEF; init = 1'b1;
      #1 check("t5 lane_ready under init", lane_ready, 1'b0);
      @(negedge clk);
      init = 1'b0; lane_valid = 1'b0;
      exp_st = '0;
      check_state("t5 cleared");
      check("t5 block_count kept", block_count, 16'd3);
      check("t5 valid", state_out_valid, 1'b0);
      send(64'hDEAD, 1'b0);
      exp_st[0][0] = 64'hDEAD;
      check_state("t5 restart");
      send(64'hCAFE, 1'b1);
      check("t5 present", state_out_valid, 1'b1);
      handshake();
      check("t5 block_count", block_count, 16'd4);

      // Test 6: asynchronous reset in WAIT_PERM
      #2 rst = 1'b1;
      #1;
      check("t6 block_count", block_count, 16'd0);
      check("t6 state_out_valid", state_out_valid, 1'b0);
      check("t6 lane_ready", lane_ready, 1'b0);
      exp_st = '0;
      check_state("t6");
      @(negedge clk);
      rst = 1'b0;
      #1 check("t6 lane_ready after reset", lane_ready, 1'b1);
      @(negedge clk);

      // RATE_LANES=21: block ends on lane count alone
      for (int i = 0; i < 21; i++) begin
         check("r21 no early present", state_out_valid21, 1'b0);
         lane_valid21 = 1'b1;
         lane_data21  = 64'(i + 1);
         #1 check("r21 lane_ready", lane_ready21, 1'b1);
         @(negedge clk);
      end
      lane_valid21 = 1'b0;
      check("r21 state_out_valid", state_out_valid21, 1'b1);
      check("r21 lane_ready in PRESENT", lane_ready21, 1'b0);
      check("r21 A[0][4]", state_out21[0][4], 64'd21);
      check("r21 A[4][3]", state_out21[4][3], 64'd20);
      check("r21 A[1][4]", state_out21[1][4], 64'd0);
      check("r21 A[4][4]", state_out21[4][4], 64'd0);
      state_out_ready21 = 1'b1;
      @(negedge clk);
      state_out_ready21 = 1'b0;
      check("r21 block_count", block_count21, 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
